// File: rtl/i2c_target_regs.sv
// -----------------------------------------------------------------------------
// i2c_target_regs
//
// Clock-synchronous I2C target with a small 8-bit register file. SCL and SDA
// are oversampled on clk, START/STOP and bit edges are decoded from the
// synchronized samples, and SDA is driven open-drain (0 or z) for ACK and
// read data. SCL is never stretched.
//
// Bus protocol handled:
//   write: START, {TARGET_ADDR,0}, pointer byte, data byte(s)..., STOP
//   read : START, {TARGET_ADDR,1}, data byte(s) out..., NACK, STOP
//   The pointer persists across transactions and auto-increments (with wrap)
//   after every byte written or read.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset; also releases SDA at once
//   i2c_scl      bus clock (input only)
//   i2c_sda      bus data, open-drain (driven only as 1'b0 or 1'bz)
//   reg_rd_idx   local read-port register index
//   reg_rd_data  combinational read of regs[reg_rd_idx]
//   wr_valid     one-clk pulse when a bus write updates a register
//   wr_idx       index of the register written (valid with wr_valid)
//   wr_data      byte written (valid with wr_valid)
//   busy         high from an address match until STOP or a NACK-ended read
// -----------------------------------------------------------------------------
module i2c_target_regs #(
   parameter logic [6:0] TARGET_ADDR = 7'b0101010,
   parameter int         NREGS       = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i2c_scl,
   inout  wire                      i2c_sda,
   input  logic [$clog2(NREGS)-1:0] reg_rd_idx,
   output logic [7:0]               reg_rd_data,
   output logic                     wr_valid,
   output logic [$clog2(NREGS)-1:0] wr_idx,
   output logic [7:0]               wr_data,
   output logic                     busy
);

   localparam int IW = $clog2(NREGS);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } state_t;

   // Register pointer advance; NREGS is a power of two so the natural
   // overflow of the IW-bit add gives the wrap to 0.
   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
      return p + IW'(1);
   endfunction

   logic              scl_p0, scl_p1, scl_p2;
   logic              sda_p0, sda_p1, sda_p2;
   logic              scl_rise, scl_fall;
   logic              bus_start, bus_stop;
   logic [7:0]        byte_in;

   state_t            state;
   logic [3:0]        cnt;
   logic [7:0]        shreg;
   logic              rw;
   logic              sda_oe;
   logic [IW-1:0]     ptr;
   logic [7:0]        regs [NREGS];

   // Open-drain output. rst gates the driver combinationally so that a reset
   // during an ACK or a read bit lets go of the bus immediately.
   assign i2c_sda = (sda_oe && !rst) ? 1'b0 : 1'bz;

   assign reg_rd_data = regs[reg_rd_idx];

   // ---- stage p0/p1: two-flop synchronizer; p2: previous sample for edges ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         scl_p2 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= i2c_scl;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= i2c_sda;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   // ---- edge / bus-condition decode on the synchronized samples ----
   assign scl_rise  =  scl_p1 & ~scl_p2;
   assign scl_fall  = ~scl_p1 &  scl_p2;
   assign bus_start =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
   assign bus_stop  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;

   // Byte as it stands once the current bit is shifted in (MSB first).
   assign byte_in = {shreg[6:0], sda_p1};

   // ---- protocol FSM, register file and write strobe ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         shreg    <= 8'h00;
         rw       <= 1'b0;
         sda_oe   <= 1'b0;
         ptr      <= '0;
         busy     <= 1'b0;
         wr_valid <= 1'b0;
         wr_idx   <= '0;
         wr_data  <= 8'h00;
         for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
      end else begin
         wr_valid <= 1'b0;
         // START/STOP take priority over any bit activity; a partially
         // received byte is simply dropped.
         if (bus_start) begin
            state  <= ADDR;
            cnt    <= 4'd0;
            sda_oe <= 1'b0;
         end else if (bus_stop) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            // Every rising edge shifts the line into shreg. In RDATA this
            // moves the next bit to be driven into shreg[7].
            if (scl_rise) shreg <= byte_in;

            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     if (cnt == 4'd7) begin
                        cnt <= 4'd0;
                        if (byte_in[7:1] == TARGET_ADDR) begin
                           state <= ADDR_ACK;
                           busy  <= 1'b1;
                           rw    <= byte_in[0];
                        end else begin
                           state <= IGNORE;
                        end
                     end else begin
                        cnt <= cnt + 4'd1;
                     end
                  end
               end

               // In the three ACK states cnt==0 means "waiting for the fall
               // that ends bit 8" and cnt==1 "waiting for the fall ending
               // the ACK bit".
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (cnt == 4'd0) begin
                        sda_oe <= 1'b1;
                        cnt    <= 4'd1;
                     end else begin
                        cnt <= 4'd0;
                        if (rw) begin
                           state  <= RDATA;
                           shreg  <= regs[ptr];
                           sda_oe <= ~regs[ptr][7];
                        end else begin
                           state  <= PTR;
                           sda_oe <= 1'b0;
                        end
                     end
                  end
               end

               PTR: begin
                  if (scl_rise) begin
                     if (cnt == 4'd7) begin
                        cnt   <= 4'd0;
                        ptr   <= byte_in[IW-1:0];
                        state <= PTR_ACK;
                     end else begin
                        cnt <= cnt + 4'd1;
                     end
                  end
               end

               PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     if (cnt == 4'd0) begin
                        sda_oe <= 1'b1;
                        cnt    <= 4'd1;
                     end else begin
                        sda_oe <= 1'b0;
                        cnt    <= 4'd0;
                        state  <= WDATA;
                     end
                  end
               end

               WDATA: begin
                  if (scl_rise) begin
                     if (cnt == 4'd7) begin
                        cnt       <= 4'd0;
                        regs[ptr] <= byte_in;
                        wr_valid  <= 1'b1;
                        wr_idx    <= ptr;
                        wr_data   <= byte_in;
                        ptr       <= ptr_inc(ptr);
                        state     <= WDATA_ACK;
                     end else begin
                        cnt <= cnt + 4'd1;
                     end
                  end
               end

               // cnt counts bits already clocked out by the controller; the
               // fall after the 8th one hands SDA back for the ACK bit.
               RDATA: begin
                  if (scl_rise) begin
                     cnt <= cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (cnt == 4'd8) begin
                        cnt    <= 4'd0;
                        sda_oe <= 1'b0;
                        state  <= RDATA_ACK;
                     end else begin
                        sda_oe <= ~shreg[7];
                     end
                  end
               end

               // Pointer advances for every byte read, ACKed or not. After an
               // ACK, cnt==1 marks that the next fall starts a new byte.
               RDATA_ACK: begin
                  if (scl_rise) begin
                     ptr <= ptr_inc(ptr);
                     if (sda_p1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                     end else begin
                        cnt <= 4'd1;
                     end
                  end else if (scl_fall && cnt == 4'd1) begin
                     cnt    <= 4'd0;
                     shreg  <= regs[ptr];
                     sda_oe <= ~regs[ptr][7];
                     state  <= RDATA;
                  end
               end

               IDLE, IGNORE: begin
                  sda_oe <= 1'b0;
               end

               default: begin
                  state  <= IDLE;
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Bench for i2c_target_regs: acts as the I2C controller on an open-drain bus
// with a pull-up, runs a table of single-byte writes, hand-written sequences
// for burst wrap, read, abort and reset-during-read, and a randomized phase
// checked against a simple array model of the register file and pointer.
// -----------------------------------------------------------------------------
module tb_i2c_target_regs;

   localparam int Q = 5;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda_low = 1'b0;
   wire        sda;
   logic [1:0] rd_idx = 2'd0;
   logic [7:0] rd_data;
   logic       wr_valid;
   logic [1:0] wr_idx;
   logic [7:0] wr_data;
   logic       busy;

   pullup (sda);
   assign sda = sda_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_target_regs dut (
      .clk         (clk),
      .rst         (rst),
      .i2c_scl     (scl),
      .i2c_sda     (sda),
      .reg_rd_idx  (rd_idx),
      .reg_rd_data (rd_data),
      .wr_valid    (wr_valid),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .busy        (busy)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Write-strobe log and count of cycles in which the target pulls SDA low.
   logic [9:0] wlog [$];
   int         pull_cnt = 0;

   always @(negedge clk) begin
      if (wr_valid) wlog.push_back({wr_idx, wr_data});
      if (!sda_low && sda === 1'b0) pull_cnt <= pull_cnt + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_low = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(2*Q);
      sda_low = 1'b1;
      wait_clk(2*Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic bus_stop();
      sda_low = 1'b1;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(2*Q);
      sda_low = 1'b0;
      wait_clk(2*Q);
   endtask

   task automatic write_bit(input logic b);
      sda_low = ~b;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(2*Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_low = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      b = sda;
      wait_clk(Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output int ack);
      logic v;
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(v);
      ack = (v == 1'b0) ? 1 : 0;
   endtask

   task automatic read_byte(output logic [7:0] d, input int give_ack);
      logic v;
      for (int i = 7; i >= 0; i--) begin
         read_bit(v);
         d[i] = v;
      end
      write_bit(give_ack != 0 ? 1'b0 : 1'b1);
   endtask

   task automatic chk_reg(input string name, input int idx, input int exp);
      rd_idx = idx[1:0];
      #1;
      check(name, int'(rd_data), exp);
   endtask

   // Write transaction: address 0x54, pointer, then n data bytes.
   task automatic write_tx(input logic [7:0] p, input logic [7:0] d [4],
                           input int n, output int acks);
      int a;
      acks = 0;
      bus_start();
      write_byte(8'h54, a); acks += a;
      write_byte(p, a);     acks += a;
      for (int i = 0; i < n; i++) begin
         write_byte(d[i], a);
         acks += a;
      end
      bus_stop();
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] ptr;
      logic [7:0] data;
      int         exp_ack;
      int         exp_wr;
      int         chk_idx;
      int         exp_val;
   } vec_t;

   vec_t vecs [4];

   // Reference model of the target's visible state.
   logic [7:0] mregs [4];
   int         mptr;

   initial begin
      int         a, acks, w0, p0, n, k, setp;
      logic [7:0] d, p, addr8;
      logic [7:0] dd [4];
      logic [6:0] a7;

      vecs[0] = '{8'h54, 8'h01, 8'hAA, 1, 1, 1, 8'hAA};
      vecs[1] = '{8'h56, 8'h02, 8'h77, 0, 0, 2, 8'h00};
      vecs[2] = '{8'h54, 8'hF2, 8'h5C, 1, 1, 2, 8'h5C};
      vecs[3] = '{8'h54, 8'h00, 8'h3C, 1, 1, 0, 8'h3C};

      // ---------------- reset state ----------------
      wait_clk(5);
      check("rst sda released", int'(sda), 1);
      check("rst busy", int'(busy), 0);
      check("rst wr_valid", int'(wr_valid), 0);
      check("rst wr_idx", int'(wr_idx), 0);
      check("rst wr_data", int'(wr_data), 0);
      for (int i = 0; i < 4; i++) chk_reg($sformatf("rst reg%0d", i), i, 0);
      rst = 1'b0;
      wait_clk(10);

      // ---------------- table: single-byte writes ----------------
      for (int v = 0; v < 4; v++) begin
         w0 = wlog.size();
         p0 = pull_cnt;
         bus_start();
         write_byte(vecs[v].addr, a);
         check($sformatf("vec%0d addr ack", v), a, vecs[v].exp_ack);
         check($sformatf("vec%0d busy", v), int'(busy), vecs[v].exp_ack);
         write_byte(vecs[v].ptr, a);
         write_byte(vecs[v].data, a);
         bus_stop();
         check($sformatf("vec%0d busy after stop", v), int'(busy), 0);
         check($sformatf("vec%0d wr count", v), wlog.size() - w0, vecs[v].exp_wr);
         if (vecs[v].exp_wr > 0 && wlog.size() > w0) begin
            check($sformatf("vec%0d wr_idx", v), int'(wlog[w0][9:8]), vecs[v].chk_idx);
            check($sformatf("vec%0d wr_data", v), int'(wlog[w0][7:0]), vecs[v].exp_val);
         end
         chk_reg($sformatf("vec%0d reg", v), vecs[v].chk_idx, vecs[v].exp_val);
         check($sformatf("vec%0d sda driven", v), (pull_cnt != p0) ? 1 : 0, vecs[v].exp_ack);
      end

      // ---------------- burst write wrapping 3 -> 0 ----------------
      w0 = wlog.size();
      dd[0] = 8'h11; dd[1] = 8'h22; dd[2] = 8'h00; dd[3] = 8'h00;
      write_tx(8'h03, dd, 2, acks);
      check("wrap acks", acks, 4);
      check("wrap wr count", wlog.size() - w0, 2);
      if (wlog.size() >= w0 + 2) begin
         check("wrap wr0", int'(wlog[w0]), {2'd3, 8'h11});
         check("wrap wr1", int'(wlog[w0+1]), {2'd0, 8'h22});
      end
      chk_reg("wrap reg3", 3, 8'h11);
      chk_reg("wrap reg0", 0, 8'h22);

      // ---------------- read with repeated START, ACK then NACK ----------------
      w0 = wlog.size();
      bus_start();
      write_byte(8'h54, a);
      write_byte(8'h03, a);
      bus_start();
      write_byte(8'h55, a);
      check("read addr ack", a, 1);
      read_byte(d, 1);
      check("read byte0", int'(d), 8'h11);
      read_byte(d, 0);
      check("read byte1", int'(d), 8'h22);
      check("read busy after nack", int'(busy), 0);
      bus_stop();
      bus_start();
      write_byte(8'h55, a);
      read_byte(d, 0);
      bus_stop();
      check("read ptr continues", int'(d), 8'hAA);
      check("read no wr", wlog.size() - w0, 0);

      // ---------------- abort mid-byte ----------------
      w0 = wlog.size();
      bus_start();
      write_byte(8'h54, a);
      write_byte(8'h02, a);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
      bus_stop();
      check("abort no wr", wlog.size() - w0, 0);
      chk_reg("abort reg2", 2, 8'h5C);
      dd[0] = 8'h99;
      write_tx(8'h02, dd, 1, acks);
      check("after abort acks", acks, 3);
      chk_reg("after abort reg2", 2, 8'h99);
      check("after abort wr count", wlog.size() - w0, 1);

      // ---------------- randomized transactions vs model ----------------
      for (int i = 0; i < 4; i++) dd[i] = 8'($urandom);
      write_tx(8'h00, dd, 4, acks);
      check("rand init acks", acks, 6);
      for (int i = 0; i < 4; i++) mregs[i] = dd[i];
      mptr = 0;

      for (int t = 0; t < 20; t++) begin
         w0 = wlog.size();
         p0 = pull_cnt;
         case ($urandom_range(0, 3))
            0, 1: begin
               p = 8'($urandom);
               n = $urandom_range(0, 3);
               for (int i = 0; i < 4; i++) dd[i] = 8'($urandom);
               write_tx(p, dd, n, acks);
               check($sformatf("rand%0d w acks", t), acks, 2 + n);
               check($sformatf("rand%0d w count", t), wlog.size() - w0, n);
               mptr = int'(p) % 4;
               for (int i = 0; i < n; i++) begin
                  if (wlog.size() > w0 + i)
                     check($sformatf("rand%0d w ev%0d", t, i), int'(wlog[w0+i]),
                           (mptr << 8) | int'(dd[i]));
                  mregs[mptr] = dd[i];
                  mptr = (mptr + 1) % 4;
               end
            end
            2: begin
               setp = $urandom_range(0, 1);
               k = $urandom_range(1, 3);
               bus_start();
               if (setp != 0) begin
                  p = 8'($urandom);
                  write_byte(8'h54, a);
                  write_byte(p, a);
                  mptr = int'(p) % 4;
                  bus_start();
               end
               write_byte(8'h55, a);
               check($sformatf("rand%0d r ack", t), a, 1);
               for (int j = 0; j < k; j++) begin
                  read_byte(d, (j < k - 1) ? 1 : 0);
                  check($sformatf("rand%0d r byte%0d", t, j), int'(d), int'(mregs[mptr]));
                  mptr = (mptr + 1) % 4;
               end
               check($sformatf("rand%0d r busy", t), int'(busy), 0);
               bus_stop();
               check($sformatf("rand%0d r no wr", t), wlog.size() - w0, 0);
            end
            default: begin
               a7 = 7'($urandom_range(0, 127));
               if (a7 == 7'h2A) a7 = 7'h2B;
               addr8 = {a7, 1'($urandom)};
               bus_start();
               write_byte(addr8, a);
               write_byte(8'($urandom), k);
               bus_stop();
               check($sformatf("rand%0d bad addr ack", t), a, 0);
               check($sformatf("rand%0d bad addr pulls", t), pull_cnt - p0, 0);
               check($sformatf("rand%0d bad addr wr", t), wlog.size() - w0, 0);
            end
         endcase
      end
      for (int i = 0; i < 4; i++) chk_reg($sformatf("rand final reg%0d", i), i, int'(mregs[i]));

      // ---------------- reset while target drives SDA in a read ----------------
      dd[0] = 8'h12;
      write_tx(8'h00, dd, 1, acks);
      bus_start();
      write_byte(8'h54, a);
      write_byte(8'h00, a);
      bus_start();
      write_byte(8'h55, a);
      check("midrd sda driven", int'(sda), 0);
      rst = 1'b1;
      #1;
      check("midrd sda released", int'(sda), 1);
      wait_clk(2);
      check("midrd busy", int'(busy), 0);
      for (int i = 0; i < 4; i++) chk_reg($sformatf("midrd reg%0d", i), i, 0);
      rst = 1'b0;
      wait_clk(5);
      scl = 1'b1;
      wait_clk(4*Q);
      w0 = wlog.size();
      dd[0] = 8'h5A;
      write_tx(8'h01, dd, 1, acks);
      check("post rst acks", acks, 3);
      chk_reg("post rst reg1", 1, 8'h5A);
      check("post rst wr count", wlog.size() - w0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Clocked I2C target (responder) that answers an I2C controller on the shared `i2c_sda`/`i2c_scl` bus and exposes a small register file. It oversamples SCL/SDA on the system clock and decodes START, STOP, address, pointer and data bytes. It drives SDA open-drain for ACK and read data. It is the bus partner of `i2cmaster` and gives the controller a deterministic, clock-synchronous target for write and read transactions.

## Interface
- `TARGET_ADDR`, default 7'b0101010: 7-bit address this target answers.
- `NREGS`, default 4: number of 8-bit registers, power of two, 2..16.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `i2c_scl` input, 1 bit: bus clock. This block never stretches SCL.
- `i2c_sda` inout, 1 bit: bus data. Driven only as 1'b0 or 1'bz; pull-up is external.
- `reg_rd_idx` input, $clog2(NREGS) bits: local read-port register index.
- `reg_rd_data` output, 8 bits: combinational read of `regs[reg_rd_idx]`.
- `wr_valid` output, 1 bit: one-cycle pulse when a bus write updates a register.
- `wr_idx` output, $clog2(NREGS) bits: index of the register written. Valid while `wr_valid` is high.
- `wr_data` output, 8 bits: byte written. Valid while `wr_valid` is high.
- `busy` output, 1 bit: high from an addressed START+address match until STOP or NACK-terminated read.

## Operation
- Input path: SCL and SDA go through a 2-FF synchronizer, then a third flop for edge detection.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Bits are sampled on SCL rising edge, MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state (repeated start included) → ADDR, bit counter cleared, SDA released.
- STOP from any state → IDLE, SDA released, `busy`=0.
- ADDR, after 8 bits:
  - bits[7:1]==TARGET_ADDR → ADDR_ACK, `busy`=1.
  - Otherwise → IGNORE. No ACK; wait for START/STOP.
- ADDR_ACK: drive SDA=0 for the 9th bit.
  - R/W=0 → PTR.
  - R/W=1 → RDATA. The shift register loads `regs[ptr]` at the falling edge that ends the ACK.
- PTR: 8-bit byte; `ptr` = byte[$clog2(NREGS)-1:0], upper bits ignored. Then PTR_ACK (ACK driven) → WDATA.
- WDATA: after 8 bits, `regs[ptr]` ← byte, `wr_valid` pulses, `ptr` ← ptr+1 mod NREGS (wraps to 0). Then WDATA_ACK (ACK driven) → WDATA.
- RDATA: drive each bit (0 → SDA low, 1 → release) after every SCL falling edge; release SDA after the 8th bit. Then RDATA_ACK samples the controller's bit:
  - ACK (0) → `ptr` increments with wrap, next byte loads → RDATA.
  - NACK (1) → IDLE, `busy`=0, ptr still incremented.
- `ptr` persists across transactions; reset to 0.
- Registers reset to 8'h00.

## Timing
- Reset values: `i2c_sda`=z, `busy`=0, `wr_valid`=0, `wr_idx`=0, `wr_data`=0, `ptr`=0, all regs 0, state IDLE.
- Reset asserted mid-transfer releases SDA asynchronously in the same instant. The bus is then ignored until a new START after `rst` deasserts.
- Each SCL high and low phase must last ≥4 clk cycles. Detection latency is 3 clk from a bus edge.
- SDA output changes 3–4 clk after SCL falling edge and is held stable through the whole SCL high phase.
- ACK assertion: from the falling edge after bit 8 to the falling edge after bit 9. Release occurs in the same clk that detects the 9th falling edge unless a read bit follows.
- `wr_valid` asserts exactly 1 clk, in the clk after the 8th data-bit rising edge is detected.
- `reg_rd_data` reflects a same-cycle write on the next clk.
- Simultaneous START/STOP detection and bit sampling: START/STOP wins; a partial byte is discarded with no register write.
- STOP or START inside the WDATA byte: the partial byte is discarded.

## Test plan
- Write: START, 0x54 (addr 0x2A, W), ptr 0x01, data 0xAA, STOP → ACK on all three bytes; regs[1]=0xAA; one `wr_valid` with `wr_idx`=1, `wr_data`=0xAA; `busy` 1→0.
- Burst wrap: ptr 0x03, data 0x11, 0x22 → regs[3]=0x11, regs[0]=0x22; two `wr_valid` pulses.
- Read: after the wrap case, a write with ptr 0x03 and no data, repeated START, 0x55, controller ACKs then NACKs → SDA bytes 0x11 then 0x22; FSM IDLE after NACK; `ptr`=1.
- Wrong address 0x56 followed by a data byte → SDA never driven low; no `wr_valid`; `busy`=0.
- Abort: START, 0x54, ptr 0x02, 4 bits of data, STOP → regs[2] unchanged, no `wr_valid`. A later full write to reg 2 succeeds.
- Reset mid-read: assert `rst` while SDA is driven low → `i2c_sda`=z immediately; all regs 0; the next transaction is ACKed normally.
